alu_input_sequencer: RTL and testbench
======================================

# alu_input_sequencer

Front-end controller for the 16-bit registered ALU (the unit with `load_A`/`load_B`/`load_Op`/`updateRes` strobes and a shared `data_in` bus). It turns a single user "enter" button, a "back" button and the data switches into a correctly ordered, one-cycle strobe sequence: operand A, then operand B, then opcode, then an automatic result update. It sits between the board I/O (switches and buttons) and the ALU register block, and it exposes its current stage for display and LED use.

## Interface
Parameters:
- `N`, 16, width of the data switches and of the ALU `data_in` bus
- `SYNC_STAGES`, 2, flip-flop depth of the button synchronizers (≥2)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `enter`  in  1  raw button (asynchronous, already debounced); rising edge advances the sequence
- `back`  in  1  raw button (asynchronous, already debounced); rising edge steps back one stage
- `data_sw`  in  N  switch value, sampled on each accepted enter
- `data_in`  out  N  registered data to the ALU
- `load_A`  out  1  one-cycle strobe: ALU captures `data_in` as A
- `load_B`  out  1  one-cycle strobe: ALU captures `data_in` as B
- `load_Op`  out  1  one-cycle strobe: ALU captures `data_in[1:0]` as opcode
- `updateRes`  out  1  one-cycle strobe: ALU updates result and flags
- `stage`  out  2  current state encoding (see Operation)
- `op_count`  out  8  number of completed operations, wraps

## Operation
- Each button passes through a `SYNC_STAGES` synchronizer, then a one-register rising-edge detector. This produces `enter_p` and `back_p` (one cycle each).
- FSM states and their `stage` codes:
  - S_A = 0
  - S_B = 1
  - S_OP = 2
  - S_RES = 3
  - internal S_UPD, which reports `stage` = 3
- S_A + `enter_p`: `data_in` ← `data_sw`, pulse `load_A`, go to S_B.
- S_B + `enter_p`: `data_in` ← `data_sw`, pulse `load_B`, go to S_OP.
- S_OP + `enter_p`: `data_in` ← `data_sw`, pulse `load_Op`, go to S_UPD.
- S_UPD: unconditionally pulse `updateRes`, increment `op_count` (mod 256), go to S_RES.
- S_RES + `enter_p`: go to S_A. No strobe and no data capture on this transition.
- `back_p` transitions:
  - S_B → S_A
  - S_OP → S_B
  - S_RES → S_OP
  - S_A stays in S_A
  - No strobes are issued on any back transition. `data_in` holds its value.
- `enter_p` and `back_p` in the same cycle: back wins and enter is discarded.
- Pulses in S_UPD are ignored. S_UPD lasts exactly one cycle.
- At most one of the four strobes is high in any cycle.
- `data_in` changes only on an accepted enter in S_A, S_B or S_OP. Otherwise it holds its value.
- Re-entering a stage via back and then pressing enter re-issues that stage's strobe with the new switch value.

## Timing
- All outputs are registered.
- Reset values: state S_A, `stage`=0, `data_in`=0, all strobes 0, `op_count`=0. Synchronizer and edge registers are cleared to 0.
- Reset asserted mid-sequence (any state, including S_UPD) aborts immediately: outputs go to their reset values asynchronously and no strobe completes.
- Latency from the first `clk` edge that samples `enter`=1: the edge detect fires after `SYNC_STAGES`+1 edges. The strobe and the new `data_in` appear on the next edge, together, so the ALU sees the value and its strobe in the same cycle.
- `updateRes` follows `load_Op` on the very next cycle. `stage` reads 3 from that cycle onward.
- A button held high produces exactly one `enter_p`. A new press requires a low level for at least one synchronized sample.
- A button that is high when reset is released does not produce an edge until it has gone low and then high again.

## Structure
- Package `alu_seq_pkg`:
  - `typedef enum logic [2:0] state_t` with S_A, S_B, S_OP, S_UPD, S_RES
  - `localparam` stage codes
- Sub-module `btn_sync_edge`: parameterized synchronizer plus rising-edge detector, instantiated once for `enter` and once for `back`.
- Top level contains the FSM, the `data_in` register and the `op_count` counter.

## Test plan
- Reset, then three enters with switches 0x0012, 0x0034, 0x0001: `load_A` with `data_in`=0x0012, then `load_B` with 0x0034, then `load_Op` with 0x0001. `updateRes` follows 1 cycle after `load_Op`, `op_count`=1, `stage`=3.
- In S_OP, press back, set switches to 0x0099, press enter: `load_B` with 0x0099 and `stage`=2. `load_A` is never re-pulsed.
- `enter` held high for 50 cycles in S_A: exactly one `load_A` pulse and `stage`=1.
- `enter` and `back` rise in the same cycle while in S_B: state goes to S_A and no strobe is issued.
- Run 256 full sequences: `op_count` wraps to 0, and a scoreboard sees exactly one strobe per enter.
- Drive `reset` low during S_UPD: `updateRes` never asserts, all outputs read 0 and `stage`=0 immediately.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and stage codes for the ALU input sequencer.
// The internal update state reports the same stage code as the result state.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_OP  = 3'd2,
    S_RES = 3'd3,
    S_UPD = 3'd4
  } state_t;

  localparam logic [1:0] STAGE_A   = 2'd0;
  localparam logic [1:0] STAGE_B   = 2'd1;
  localparam logic [1:0] STAGE_OP  = 2'd2;
  localparam logic [1:0] STAGE_RES = 2'd3;

  localparam int OP_COUNT_W = 8;

  function automatic logic [1:0] stage_of(input state_t s);
    logic [1:0] code;
    case (s)
      S_A:          code = STAGE_A;
      S_B:          code = STAGE_B;
      S_OP:         code = STAGE_OP;
      S_UPD, S_RES: code = STAGE_RES;
      default:      code = STAGE_A;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer plus registered rising-edge detector.
// A press is only recognised once a genuine low sample has passed through the chain.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   pulse_q, pulse_d;
  logic                   synced;
  logic                   synced_valid;

  assign synced       = sync_q[SYNC_STAGES-1];
  assign synced_valid = fill_q[SYNC_STAGES-1];

  // fill_q marks when the synchronizer output holds a real sample rather than
  // its reset value, so a button held across reset release cannot arm early.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    prev_d  = synced;
    armed_d = armed_q | (synced_valid & ~synced);
    pulse_d = synced & ~prev_q & armed_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Enter/back button front-end that issues ordered one-cycle load strobes to the ALU.
// All outputs are registered; the strobe and its data_in value appear in the same cycle.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enter,
  input  logic                  back,
  input  logic [N-1:0]          data_sw,
  output logic [N-1:0]          data_in,
  output logic                  load_A,
  output logic                  load_B,
  output logic                  load_Op,
  output logic                  updateRes,
  output logic [1:0]            stage,
  output logic [OP_COUNT_W-1:0] op_count
);

  logic enter_p;
  logic back_p;
  logic accept_enter;

  state_t                  state_q, state_d;
  logic [N-1:0]            data_q, data_d;
  logic                    load_a_q, load_a_d;
  logic                    load_b_q, load_b_d;
  logic                    load_op_q, load_op_d;
  logic                    upd_q, upd_d;
  logic [1:0]              stage_q, stage_d;
  logic [OP_COUNT_W-1:0]   count_q, count_d;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (enter),
    .pulse_o (enter_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_back_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (back),
    .pulse_o (back_p)
  );

  // Back has priority: a coincident enter is dropped.
  assign accept_enter = enter_p & ~back_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_A;
      data_q    <= '0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      load_op_q <= 1'b0;
      upd_q     <= 1'b0;
      stage_q   <= STAGE_A;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      load_op_q <= load_op_d;
      upd_q     <= upd_d;
      stage_q   <= stage_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A: begin
        if (accept_enter) state_d = S_B;
      end
      S_B: begin
        if (back_p)            state_d = S_A;
        else if (accept_enter) state_d = S_OP;
      end
      S_OP: begin
        if (back_p)            state_d = S_B;
        else if (accept_enter) state_d = S_UPD;
      end
      S_UPD: begin
        state_d = S_RES;
      end
      S_RES: begin
        if (back_p)            state_d = S_OP;
        else if (accept_enter) state_d = S_A;
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // Stage is computed from the next state so it lines up with the strobe cycle.
  always_comb begin
    data_d    = data_q;
    load_a_d  = 1'b0;
    load_b_d  = 1'b0;
    load_op_d = 1'b0;
    upd_d     = 1'b0;
    count_d   = count_q;
    stage_d   = stage_of(state_d);
    case (state_q)
      S_A: begin
        if (accept_enter) begin
          data_d   = data_sw;
          load_a_d = 1'b1;
        end
      end
      S_B: begin
        if (accept_enter) begin
          data_d   = data_sw;
          load_b_d = 1'b1;
        end
      end
      S_OP: begin
        if (accept_enter) begin
          data_d    = data_sw;
          load_op_d = 1'b1;
        end
      end
      S_UPD: begin
        upd_d   = 1'b1;
        count_d = count_q + 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign data_in   = data_q;
  assign load_A    = load_a_q;
  assign load_B    = load_b_q;
  assign load_Op   = load_op_q;
  assign updateRes = upd_q;
  assign stage     = stage_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed and random stimulus for alu_input_sequencer, checked against a stage-level model.
module tb_alu_input_sequencer;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         enter;
  logic         back;
  logic [N-1:0] data_sw;
  logic [N-1:0] data_in;
  logic         load_A, load_B, load_Op, updateRes;
  logic [1:0]   stage;
  logic [7:0]   op_count;

  alu_input_sequencer #(.N(N), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enter     (enter),
    .back      (back),
    .data_sw   (data_sw),
    .data_in   (data_in),
    .load_A    (load_A),
    .load_B    (load_B),
    .load_Op   (load_Op),
    .updateRes (updateRes),
    .stage     (stage),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = load_A, 1 = load_B, 2 = load_Op, 3 = updateRes
  typedef struct packed {
    int           kind;
    logic [N-1:0] data;
    int           at;
  } ev_t;

  ev_t obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stage index 0..3, completed-operation count, last captured data
  int           m_stage;
  int           m_count;
  int           m_total;
  logic [N-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && (load_A || load_B || load_Op || updateRes)) begin
      chk("onehot", $countones({load_A, load_B, load_Op, updateRes}), 1);
      obs_q.push_back('{load_A ? 0 : load_B ? 1 : load_Op ? 2 : 3, data_in, cyc});
    end
  end

  task automatic do_press(input bit en, input bit bk, input logic [N-1:0] sw, input int hold);
    ev_t exp_q[$];
    int  s;
    @(negedge clk);
    obs_q.delete();
    s       = cyc;
    data_sw = sw;
    enter   = en;
    back    = bk;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    back  = 1'b0;
    repeat (8) @(negedge clk);
    if (bk) begin
      if (m_stage > 0) m_stage--;
    end else if (en) begin
      if (m_stage < 3) begin
        exp_q.push_back('{m_stage, sw, s + 4});
        m_data = sw;
        if (m_stage == 2) begin
          exp_q.push_back('{3, sw, s + 5});
          m_count = (m_count + 1) % 256;
          m_total++;
          m_stage = 3;
        end else begin
          m_stage++;
        end
      end else begin
        m_stage = 0;
      end
    end
    chk("n_strobes", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        chk("strobe_kind", obs_q[i].kind, exp_q[i].kind);
        chk("strobe_data", obs_q[i].data, exp_q[i].data);
        chk("strobe_cycle", obs_q[i].at, exp_q[i].at);
      end
    end
    chk("stage", stage, m_stage);
    chk("data_in", data_in, m_data);
    chk("op_count", op_count, m_count);
  endtask

  initial begin
    int s;
    int nupd;
    int nlate;
    int start_total;
    int r;

    reset   = 1'b0;
    enter   = 1'b0;
    back    = 1'b0;
    data_sw = '0;
    m_stage = 0;
    m_count = 0;
    m_total = 0;
    m_data  = '0;

    repeat (3) @(negedge clk);
    chk("rst_data_in", data_in, 0);
    chk("rst_strobes", {load_A, load_B, load_Op, updateRes}, 0);
    chk("rst_stage", stage, 0);
    chk("rst_op_count", op_count, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Basic A, B, opcode sequence with automatic update
    do_press(1, 0, 16'h0012, 2);
    do_press(1, 0, 16'h0034, 2);
    do_press(1, 0, 16'h0001, 2);

    // Result -> A, then A and B, then back from opcode and re-enter B
    do_press(1, 0, 16'h1111, 2);
    do_press(1, 0, 16'($urandom), 2);
    do_press(1, 0, 16'($urandom), 2);
    do_press(0, 1, 16'h0000, 2);
    do_press(1, 0, 16'h0099, 2);

    // Back to A, then a long held enter gives a single load_A
    do_press(0, 1, 16'h0000, 3);
    do_press(0, 1, 16'h0000, 3);
    do_press(0, 1, 16'h0000, 3);
    do_press(1, 0, 16'h5A5A, 50);

    // Enter and back together in S_B: back wins, no strobe
    do_press(1, 1, 16'hFFFF, 3);

    // Random mix of enters/backs over 256 completed operations (op_count wraps)
    start_total = m_total;
    while (m_total < start_total + 256) begin
      r = $urandom_range(0, 99);
      if (r < 80)      do_press(1, 0, 16'($urandom), $urandom_range(1, 6));
      else if (r < 95) do_press(0, 1, 16'($urandom), $urandom_range(1, 6));
      else             do_press(1, 1, 16'($urandom), $urandom_range(1, 6));
    end

    // Walk to the opcode stage, then reset in the update cycle with enter still held
    while (m_stage != 2) begin
      if (m_stage == 3) do_press(1, 0, 16'h0000, 2);
      else              do_press(1, 0, 16'($urandom), 2);
    end
    @(negedge clk);
    obs_q.delete();
    s       = cyc;
    data_sw = 16'h0003;
    enter   = 1'b1;
    repeat (4) @(negedge clk);
    chk("load_Op_before_reset", load_Op, 1);
    reset = 1'b0;
    #1;
    chk("abort_data_in", data_in, 0);
    chk("abort_strobes", {load_A, load_B, load_Op, updateRes}, 0);
    chk("abort_stage", stage, 0);
    chk("abort_op_count", op_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    enter = 1'b0;
    repeat (10) @(negedge clk);
    nupd  = 0;
    nlate = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == 3) nupd++;
      if (obs_q[i].at > s + 4) nlate++;
    end
    chk("no_updateRes_after_abort", nupd, 0);
    chk("held_enter_no_strobe", nlate, 0);
    chk("post_abort_stage", stage, 0);
    m_stage = 0;
    m_count = 0;
    m_data  = '0;

    do_press(1, 0, 16'hBEEF, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
